// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the fetch/data/memory bus arbiter.
//   ibus_*  : instruction-fetch port (single 32-bit word per beat)
//   dbus_*  : data port (up to 64-bit, byte strobes, writes when any strobe set)
//   cbus_*  : the single-port memory bus shared by both
//   arb_state_t : arbiter ownership, encoded to match the debug 'owner' output
package mem_bus_arbiter_pkg;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_I    = 2'd1,
    ARB_D    = 2'd2
  } arb_state_t;

  // Pick the 32-bit half of a 64-bit beat addressed by addr[2].
  function automatic logic [31:0] word_sel(input logic [63:0] d, input logic hi);
    return hi ? d[63:32] : d[31:0];
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between the fetch port and the data port.
// Data port has fixed priority; after MAX_D_STREAK consecutive data grants with
// a fetch waiting, the next grant goes to fetch. One single-beat transfer is
// outstanding at a time; the granted request is latched so the transfer runs to
// completion even if its requester flushes.
//
// Ports
//   clk    in   clock, all state on posedge
//   rst    in   asynchronous active-low reset
//   ireq   in   fetch request           iresp  out  fetch response
//   dreq   in   data request            dresp  out  data response
//   creq   out  memory bus request      cresp  in   memory bus response
//   owner  out  0 idle, 1 fetch busy, 2 data busy
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp,
  output logic [1:0] owner
);

  localparam logic [2:0] STREAK_MAX = 3'(MAX_D_STREAK);

  arb_state_t r_state, w_state_nxt;
  logic [2:0] r_streak, w_streak_nxt;
  cbus_req_t  r_req, w_req_nxt;
  logic       w_grant_i, w_grant_d, w_starve;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ARB_IDLE;
      r_streak <= '0;
      r_req    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
      r_req    <= w_req_nxt;
    end
  end

  // The latched request's valid bit is set on grant and cleared on completion,
  // so it is exactly the bus valid and can never be high while idle.
  always_comb begin
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    w_req_nxt    = r_req;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    w_starve     = ireq.valid && (r_streak == STREAK_MAX);
    iresp        = '0;
    dresp        = '0;
    creq         = r_req;
    owner        = r_state;

    unique case (r_state)
      ARB_IDLE: begin
        if (dreq.valid && !w_starve) w_grant_d = 1'b1;
        else if (ireq.valid)         w_grant_i = 1'b1;

        // Streak only measures data grants made while a fetch is waiting.
        if (!ireq.valid || w_grant_i)
          w_streak_nxt = '0;
        else if (w_grant_d && r_streak != STREAK_MAX)
          w_streak_nxt = r_streak + 3'd1;

        if (w_grant_d) begin
          w_req_nxt = '{valid: 1'b1, is_write: |dreq.strobe, addr: dreq.addr,
                        size: dreq.size, strobe: dreq.strobe, data: dreq.data};
          w_state_nxt = ARB_D;
        end else if (w_grant_i) begin
          w_req_nxt = '{valid: 1'b1, is_write: 1'b0, addr: ireq.addr,
                        size: SIZE_WORD, strobe: 8'h00, data: 64'h0};
          w_state_nxt = ARB_I;
        end

        // The state register is already idle under reset, but the grant is
        // combinational on live inputs and must be masked explicitly.
        iresp.addr_ok = w_grant_i && rst;
        dresp.addr_ok = w_grant_d && rst;
      end

      ARB_I, ARB_D: begin
        if (cresp.ready) begin
          w_state_nxt     = ARB_IDLE;
          w_req_nxt.valid = 1'b0;
          // A requester that dropped valid has flushed: swallow the beat.
          if (r_state == ARB_I && ireq.valid) begin
            iresp.data_ok = 1'b1;
            iresp.data    = word_sel(cresp.data, r_req.addr[2]);
          end
          if (r_state == ARB_D && dreq.valid) begin
            dresp.data_ok = 1'b1;
            dresp.data    = cresp.data;
          end
        end
      end

      default: w_state_nxt = ARB_IDLE;
    endcase
  end

endmodule
